// File: rtl/noc_flit_mux2.sv
// rtl/noc_flit_mux2.sv - two-input flit mux with one-hot select and registered output
module noc_flit_mux2 #(
    parameter int unsigned DATAW_P1 = 66,
    parameter int unsigned VCHW_P1  = 2,
    parameter int unsigned PORT_P1  = 5
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [DATAW_P1-1:0] idata_0,
    input  logic                ivalid_0,
    input  logic [VCHW_P1-1:0]  ivch_0,
    input  logic [DATAW_P1-1:0] idata_1,
    input  logic                ivalid_1,
    input  logic [VCHW_P1-1:0]  ivch_1,
    input  logic [PORT_P1-1:0]  sel,
    output logic [DATAW_P1-1:0] odata,
    output logic                ovalid,
    output logic [VCHW_P1-1:0]  ovch
);

    logic [DATAW_P1-1:0] odata_d,  odata_q;
    logic                ovalid_d, ovalid_q;
    logic [VCHW_P1-1:0]  ovch_d,   ovch_q;

    // Only the two low select bits name a source; the rest belong to other ports.
    logic sel_hi_unused;
    assign sel_hi_unused = |sel[PORT_P1-1:2];

    // Input 0 wins when both low select bits are set; data and vch pass even when invalid.
    always_comb begin
        odata_d  = '0;
        ovalid_d = 1'b0;
        ovch_d   = '0;
        if (sel[0]) begin
            odata_d  = idata_0;
            ovalid_d = ivalid_0;
            ovch_d   = ivch_0;
        end else if (sel[1]) begin
            odata_d  = idata_1;
            ovalid_d = ivalid_1;
            ovch_d   = ivch_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;

endmodule

// File: tb/tb_noc_flit_mux2.sv
// tb/tb_noc_flit_mux2.sv - randomized and directed checks of noc_flit_mux2 against a behavioural model
module tb_noc_flit_mux2;

    logic        clk = 1'b0;
    logic        rst_;
    logic [65:0] idata_0, idata_1;
    logic        ivalid_0, ivalid_1;
    logic [1:0]  ivch_0, ivch_1;
    logic [4:0]  sel;
    logic [65:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [65:0] d;
        logic        v;
        logic [1:0]  c;
    } trip_t;

    trip_t exp_q[$];
    logic [65:0] pkt [22];

    noc_flit_mux2 #(.DATAW_P1(66), .VCHW_P1(2), .PORT_P1(5)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest-numbered selected port among {0,1} is the source; -1 means none.
    function automatic int source_of(input logic [4:0] s);
        for (int p = 0; p < 2; p++)
            if (s[p]) return p;
        return -1;
    endfunction

    always @(posedge clk) begin
        trip_t t;
        t = '0;
        if (rst_ === 1'b1) begin
            case (source_of(sel))
                0: t = '{d: idata_0, v: ivalid_0, c: ivch_0};
                1: t = '{d: idata_1, v: ivalid_1, c: ivch_1};
                default: t = '0;
            endcase
        end
        exp_q.push_back(t);
    end

    always @(negedge clk) begin
        trip_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("model_odata", odata, e.d);
            chk("model_ovalid", {65'b0, ovalid}, {65'b0, e.v});
            chk("model_ovch", {64'b0, ovch}, {64'b0, e.c});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] rnd66();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic rand_in0();
        idata_0  = rnd66();
        ivalid_0 = 1'($urandom);
        ivch_0   = 2'($urandom);
    endtask

    task automatic chk_out(input string name, input logic [65:0] d, input logic v, input logic [1:0] c);
        chk({name, "_odata"}, odata, d);
        chk({name, "_ovalid"}, {65'b0, ovalid}, {65'b0, v});
        chk({name, "_ovch"}, {64'b0, ovch}, {64'b0, c});
    endtask

    initial begin
        logic [63:0] w;
        pkt[0] = {2'b01, 32'h0, 32'h04};
        for (int i = 0; i < 20; i++) begin
            w = 64'h1 << i;
            pkt[i+1] = {2'b00, (i % 2 == 0) ? w : ~w};
        end
        pkt[21] = {2'b10, 64'h0000_0000_7FFF_8000};

        // Reset held with a valid, selected flit waiting on input 1.
        rst_ = 1'b0; sel = 5'b00010;
        idata_1 = 66'h1_FFFF_FFFF_FFFF_FFFF; ivalid_1 = 1'b1; ivch_1 = 2'b11;
        rand_in0();
        step(); chk_out("reset0", 66'h0, 1'b0, 2'b00);
        step(); chk_out("reset1", 66'h0, 1'b0, 2'b00);

        // Input 1 packet, input 0 carries noise.
        rst_ = 1'b1;
        for (int i = 0; i < 22; i++) begin
            idata_1 = pkt[i]; ivalid_1 = 1'b1; ivch_1 = 2'b01; rand_in0();
            step(); chk_out("pkt1", pkt[i], 1'b1, 2'b01);
        end

        // Input 0 single flit.
        sel = 5'b00001; idata_0 = {2'b01, 32'h0, 32'h09}; ivalid_0 = 1'b1; ivch_0 = 2'b10;
        idata_1 = rnd66(); ivalid_1 = 1'b1; ivch_1 = 2'b01;
        step(); chk_out("sel0", {2'b01, 32'h0, 32'h09}, 1'b1, 2'b10);

        // No source, priority, high-bits-only select.
        sel = 5'b00000; idata_0 = rnd66(); ivalid_0 = 1'b1; idata_1 = rnd66(); ivalid_1 = 1'b1;
        step(); chk_out("nosel", 66'h0, 1'b0, 2'b00);
        sel = 5'b00011; idata_0 = 66'h2_1234_5678_9ABC_DEF0; ivch_0 = 2'b11;
        step(); chk_out("prio", 66'h2_1234_5678_9ABC_DEF0, 1'b1, 2'b11);
        sel = 5'b11100;
        step(); chk_out("hisel", 66'h0, 1'b0, 2'b00);

        // Idle cycles then invalid passthrough.
        sel = 5'b00010;
        for (int i = 0; i < 7; i++) begin
            idata_1 = 66'h0; ivalid_1 = 1'b0; ivch_1 = 2'b00; rand_in0();
            step(); chk_out("idle", 66'h0, 1'b0, 2'b00);
        end
        idata_1 = 66'h3_0000_0000_DEAD_BEEF; ivalid_1 = 1'b0; ivch_1 = 2'b01;
        step(); chk_out("invpass", 66'h3_0000_0000_DEAD_BEEF, 1'b0, 2'b01);

        // Source switch at flit 10.
        idata_0 = 66'h1_AAAA_5555_0000_FFFF; ivalid_0 = 1'b1; ivch_0 = 2'b10;
        for (int i = 0; i < 22; i++) begin
            sel = (i >= 10) ? 5'b00001 : 5'b00010;
            idata_1 = pkt[i]; ivalid_1 = 1'b1; ivch_1 = 2'b01;
            step();
            if (i < 10) chk_out("presw", pkt[i], 1'b1, 2'b01);
            else        chk_out("postsw", 66'h1_AAAA_5555_0000_FFFF, 1'b1, 2'b10);
        end

        // One-cycle reset pulse at flit 5.
        sel = 5'b00010;
        for (int i = 0; i < 22; i++) begin
            rst_ = (i == 5) ? 1'b0 : 1'b1;
            idata_1 = pkt[i]; ivalid_1 = 1'b1; ivch_1 = 2'b01; rand_in0();
            step();
            if (i == 5) chk_out("rstpulse", 66'h0, 1'b0, 2'b00);
            else        chk_out("rstpkt", pkt[i], 1'b1, 2'b01);
        end

        // Random soak; the model process checks every cycle.
        for (int i = 0; i < 400; i++) begin
            rst_ = ($urandom_range(0, 19) != 0);
            sel  = 5'($urandom);
            rand_in0();
            idata_1 = rnd66(); ivalid_1 = 1'($urandom); ivch_1 = 2'($urandom);
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
